// File: rtl/pipeline_hazard_arbiter.sv
// Priority arbiter that turns per-source hazard requests into pipeline stall/flush vectors,
// with a one-cycle force-advance on masked releases and a hold watchdog that flushes the pipe.
module pipeline_hazard_arbiter #(
   parameter int              NSTAGE   = 6,
   parameter int              NREQ     = 8,
   parameter logic [NREQ-1:0] REL_MASK = '0,
   parameter int              TIMEOUT  = 1024
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NREQ-1:0]          req_valid_i,
   input  logic [NREQ*NSTAGE-1:0]   req_stall_i,
   input  logic [NREQ*NSTAGE-1:0]   req_flush_i,
   input  logic                     cnt_clr_i,
   output logic [NSTAGE-1:0]        stall_o,
   output logic [NSTAGE-1:0]        flush_o,
   output logic [NREQ-1:0]          grant_o,
   output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] grant_idx_o,
   output logic                     force_adv_o,
   output logic                     timeout_o,
   output logic [31:0]              stall_cnt_o
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int HW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [HW-1:0] HOLD_LIM = HW'(TIMEOUT);

   logic [NREQ-1:0]   prev_valid;
   logic [NREQ-1:0]   rel;
   logic [NREQ-1:0]   eligible;
   logic [NREQ-1:0]   sel_grant;
   logic [NSTAGE-1:0] sel_stall;
   logic [NSTAGE-1:0] sel_flush;
   logic [IW-1:0]     win_idx;
   logic [IW-1:0]     last_idx;
   logic              win;
   logic              last_win;
   logic              same;
   logic              fire;
   logic              timeout_r;
   logic [HW-1:0]     hold_cnt;
   logic [HW-1:0]     hold_next;
   logic [31:0]       stall_cnt;

   assign rel = prev_valid & ~req_valid_i & REL_MASK;

   always_comb begin
      // A release masks off itself and every lower-priority source for one cycle
      eligible = '1;
      for (int i = 0; i < NREQ; i++) begin
         if (rel[i]) begin
            for (int j = 0; j <= i; j++) eligible[j] = 1'b0;
         end
      end
      win       = 1'b0;
      win_idx   = '0;
      sel_grant = '0;
      sel_stall = '0;
      sel_flush = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (req_valid_i[i] && eligible[i]) begin
            win       = 1'b1;
            win_idx   = IW'(i);
            sel_grant = '0;
            sel_grant[i] = 1'b1;
            sel_stall = req_stall_i[i*NSTAGE +: NSTAGE];
            sel_flush = req_flush_i[i*NSTAGE +: NSTAGE];
         end
      end
      if (!rst_n || timeout_r) begin
         win       = 1'b0;
         win_idx   = '0;
         sel_grant = '0;
         sel_stall = '0;
         sel_flush = '1;
      end
   end

   assign stall_o     = sel_stall;
   assign flush_o     = sel_flush;
   assign grant_o     = sel_grant;
   assign grant_idx_o = win_idx;
   assign force_adv_o = rst_n & ~timeout_r & (|rel);
   assign timeout_o   = timeout_r;
   assign stall_cnt_o = stall_cnt;

   // hold_next is the length of the current winner's run including this cycle
   assign same      = win && last_win && (win_idx == last_idx);
   assign hold_next = same ? hold_cnt + 1'b1 : HW'(1);
   assign fire      = (TIMEOUT != 0) && win && (hold_next == HOLD_LIM);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_valid <= '0;
         hold_cnt   <= '0;
         timeout_r  <= 1'b0;
         last_win   <= 1'b0;
         last_idx   <= '0;
         stall_cnt  <= '0;
      end else begin
         prev_valid <= req_valid_i;
         timeout_r  <= fire;
         last_win   <= win;
         last_idx   <= win_idx;
         if (!win || fire || (TIMEOUT == 0)) hold_cnt <= '0;
         else                                 hold_cnt <= hold_next;
         if (cnt_clr_i)                                stall_cnt <= '0;
         else if ((|sel_stall) && (stall_cnt != '1))   stall_cnt <= stall_cnt + 32'd1;
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_arbiter.sv
// Directed bench for pipeline_hazard_arbiter: stimulus pushes expected outputs into a queue,
// a negedge monitor pops and compares them.
module tb_pipeline_hazard_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  req_valid = '0;
   logic [47:0] req_stall = '0;
   logic [47:0] req_flush = '0;
   logic        cnt_clr = 1'b0;
   logic [5:0]  stall;
   logic [5:0]  flush;
   logic [7:0]  grant;
   logic [2:0]  grant_idx;
   logic        force_adv;
   logic        timeout;
   logic [31:0] stall_cnt;

   logic        s_rst = 1'b0;
   logic [7:0]  s_valid = '0;
   logic [47:0] s_stall = '0;
   logic [47:0] s_flush = '0;
   logic        s_clr = 1'b0;

   typedef struct packed {
      int          id;
      logic [5:0]  stall;
      logic [5:0]  flush;
      logic [2:0]  gi;
      logic [7:0]  grant;
      logic        fa;
      logic        to;
      logic        ck;
      logic [31:0] cnt;
   } exp_t;

   exp_t exp_q[$];
   int   tests = 0;
   int   failed = 0;
   int   step_id = 0;

   always #5 clk = ~clk;

   pipeline_hazard_arbiter #(
      .NSTAGE(6), .NREQ(8), .REL_MASK(8'h20), .TIMEOUT(4)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .req_valid_i(req_valid),
      .req_stall_i(req_stall),
      .req_flush_i(req_flush),
      .cnt_clr_i(cnt_clr),
      .stall_o(stall),
      .flush_o(flush),
      .grant_o(grant),
      .grant_idx_o(grant_idx),
      .force_adv_o(force_adv),
      .timeout_o(timeout),
      .stall_cnt_o(stall_cnt)
   );

   task automatic chk(input int id, input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         failed++;
         $display("FAIL step %0d %s: got %h expected %h", id, name, act, req);
      end
   endtask

   task automatic src(input int i, input logic v, input logic [5:0] st, input logic [5:0] fl);
      s_valid[i]         = v;
      s_stall[i*6 +: 6]  = st;
      s_flush[i*6 +: 6]  = fl;
   endtask

   // Apply staged inputs just after the next rising edge and queue that cycle's expectation
   task automatic step(input logic [5:0] es, input logic [5:0] ef, input logic [2:0] gi,
                       input logic [7:0] g, input logic fa, input logic to,
                       input logic ck, input logic [31:0] c);
      exp_t e;
      @(posedge clk);
      #1;
      rst_n     = s_rst;
      req_valid = s_valid;
      req_stall = s_stall;
      req_flush = s_flush;
      cnt_clr   = s_clr;
      step_id++;
      e.id = step_id; e.stall = es; e.flush = ef; e.gi = gi; e.grant = g;
      e.fa = fa; e.to = to; e.ck = ck; e.cnt = c;
      exp_q.push_back(e);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk(e.id, "stall_o",     32'(stall),     32'(e.stall));
            chk(e.id, "flush_o",     32'(flush),     32'(e.flush));
            chk(e.id, "grant_idx_o", 32'(grant_idx), 32'(e.gi));
            chk(e.id, "grant_o",     32'(grant),     32'(e.grant));
            chk(e.id, "force_adv_o", 32'(force_adv), 32'(e.fa));
            chk(e.id, "timeout_o",   32'(timeout),   32'(e.to));
            if (e.ck) chk(e.id, "stall_cnt_o", stall_cnt, e.cnt);
         end
      end
   end

   initial begin : guard
      #100000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "bench time limit");
   end

   initial begin : stim
      // reset values, then release with no requests
      step(6'h00, 6'h3F, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1, 32'd0);
      step(6'h00, 6'h3F, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1, 32'd0);
      s_rst = 1'b1;
      step(6'h00, 6'h00, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1, 32'd0);

      // two sources compete, src 5 released with force-advance
      src(2, 1'b1, 6'h03, 6'h04);
      src(5, 1'b1, 6'h0F, 6'h10);
      for (int k = 0; k < 3; k++) step(6'h0F, 6'h10, 3'd5, 8'h20, 1'b0, 1'b0, 1'b0, 32'd0);
      src(5, 1'b0, 6'h00, 6'h00);
      step(6'h00, 6'h00, 3'd0, 8'h00, 1'b1, 1'b0, 1'b0, 32'd0);
      step(6'h03, 6'h04, 3'd2, 8'h04, 1'b0, 1'b0, 1'b0, 32'd0);
      src(2, 1'b0, 6'h00, 6'h00);
      s_clr = 1'b1;
      step(6'h00, 6'h00, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1, 32'd4);
      s_clr = 1'b0;
      step(6'h00, 6'h00, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1, 32'd0);

      // watchdog with TIMEOUT=4
      src(3, 1'b1, 6'h07, 6'h08);
      for (int k = 0; k < 4; k++) step(6'h07, 6'h08, 3'd3, 8'h08, 1'b0, 1'b0, 1'b0, 32'd0);
      step(6'h00, 6'h3F, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0, 32'd0);
      step(6'h07, 6'h08, 3'd3, 8'h08, 1'b0, 1'b0, 1'b0, 32'd0);
      src(3, 1'b0, 6'h00, 6'h00);
      s_clr = 1'b1;
      step(6'h00, 6'h00, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1, 32'd5);
      s_clr = 1'b0;

      // five alternating stall cycles, then clear together with a stall
      for (int k = 0; k < 7; k++) begin
         if (k % 2 == 0) begin
            src(1, 1'b0, 6'h00, 6'h00);
            src(0, 1'b1, 6'h01, 6'h20);
         end else begin
            src(0, 1'b0, 6'h00, 6'h00);
            src(1, 1'b1, 6'h02, 6'h10);
         end
         s_clr = (k == 5);
         if (k % 2 == 0) step(6'h01, 6'h20, 3'd0, 8'h01, 1'b0, 1'b0, 1'b1, (k == 6) ? 32'd0 : 32'(k));
         else            step(6'h02, 6'h10, 3'd1, 8'h02, 1'b0, 1'b0, 1'b1, 32'(k));
      end
      s_clr = 1'b0;

      // saturation from a preloaded count
      src(0, 1'b0, 6'h00, 6'h00);
      step(6'h00, 6'h00, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 32'd0);
      #2;
      force dut.stall_cnt = 32'hFFFF_FFFE;
      #1;
      release dut.stall_cnt;
      src(0, 1'b1, 6'h01, 6'h20);
      step(6'h01, 6'h20, 3'd0, 8'h01, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE);
      src(0, 1'b0, 6'h00, 6'h00);
      src(1, 1'b1, 6'h02, 6'h10);
      step(6'h02, 6'h10, 3'd1, 8'h02, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
      src(1, 1'b0, 6'h00, 6'h00);
      src(0, 1'b1, 6'h01, 6'h20);
      step(6'h01, 6'h20, 3'd0, 8'h01, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
      src(0, 1'b0, 6'h00, 6'h00);
      step(6'h00, 6'h00, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);

      // reset during an active grant of a force-advance source
      src(5, 1'b1, 6'h0F, 6'h10);
      step(6'h0F, 6'h10, 3'd5, 8'h20, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
      s_rst = 1'b0;
      step(6'h00, 6'h3F, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1, 32'd0);
      s_rst = 1'b1;
      src(5, 1'b0, 6'h00, 6'h00);
      step(6'h00, 6'h00, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1, 32'd0);
      step(6'h00, 6'h00, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1, 32'd0);

      @(negedge clk);
      #1;
      tests++;
      if (exp_q.size() != 0) begin
         failed++;
         $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
